// File: rtl/fetch_branch_unit_if.sv
// Instruction-memory fetch bus between fetch_branch_unit (master) and the
// instruction memory (slave). imem_req is held until imem_valid returns.
interface fetch_branch_unit_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit: holds the PC, fetches instruction words over the imem
// bus, presents opcode/imm to the decoder, resolves branches/call/ret using
// the E/GT flags register and supplies the call link address.
// Optional feature macro: ILLEGAL_OP_TRAP_EN -- opcodes 5'b10101..5'b11111
// trap to TRAP_VEC with a one-cycle illegal pulse. When undefined those
// opcodes execute as NOP and illegal is tied low.
module fetch_branch_unit #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    parameter logic [PC_W-1:0] TRAP_VEC = PC_W'(16'h0004)
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_branch_unit_if.master imem,
    output logic [INSTR_W-1:0]  instr,
    output logic [4:0]          opcode,
    output logic                imm,
    output logic                instr_valid,
    input  logic                exec_done,
    input  logic                isBeq,
    input  logic                isBgt,
    input  logic                isUBranch,
    input  logic                isCall,
    input  logic                isRet,
    input  logic                cmp_valid,
    input  logic                cmp_eq,
    input  logic                cmp_gt,
    input  logic [PC_W-1:0]     ret_addr,
    output logic [PC_W-1:0]     link_pc,
    output logic [PC_W-1:0]     pc,
    output logic                flag_e,
    output logic                flag_gt,
    output logic                illegal
);
    localparam int OFF_W = 27;

    typedef enum logic [1:0] {FETCH, WAIT, EXEC} stateType;

    stateType           stateReg, stateNext;
    // Low during reset and for the cycle after release, so the first request
    // appears only after the first clock edge following reset.
    logic               armedReg;
    logic [PC_W-1:0]    pcReg, pcNext;
    logic [INSTR_W-1:0] instrReg;
    logic               flagEReg, flagGtReg;
    logic               execFire;
    logic               trapFire;
    logic [PC_W-1:0]    offsetExt;

    assign execFire = (stateReg == EXEC) && exec_done;

    // Branch offset: sign-extend or truncate the 27-bit field to PC width.
    generate
        if (PC_W <= OFF_W) begin : gOffTrunc
            assign offsetExt = instrReg[PC_W-1:0];
        end else begin : gOffSext
            assign offsetExt = {{(PC_W-OFF_W){instrReg[OFF_W-1]}}, instrReg[OFF_W-1:0]};
        end
    endgenerate

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegalReg;
    assign trapFire = execFire && (instrReg[INSTR_W-1 -: 5] >= 5'b10101);
    assign illegal  = illegalReg;

    // One-cycle pulse on the edge that retires an illegal opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegalReg <= 1'b0;
        else        illegalReg <= trapFire;
    end
`else
    assign trapFire = 1'b0;
    assign illegal  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= FETCH;
            armedReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            armedReg <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            FETCH:   if (armedReg)        stateNext = WAIT;
            WAIT:    if (imem.imem_valid) stateNext = EXEC;
            EXEC:    if (exec_done)       stateNext = FETCH;
            default:                      stateNext = FETCH;
        endcase
    end

    // FSM outputs: request while fetching/waiting, instruction valid in EXEC.
    always_comb begin
        imem.imem_req = armedReg && (stateReg != EXEC);
        instr_valid   = (stateReg == EXEC);
    end

    // Next-PC selection; flags used here are the values before this cycle.
    always_comb begin
        pcNext = pcReg;
        if (execFire) begin
            if (isRet)                       pcNext = ret_addr;
            else if (isUBranch || isCall)    pcNext = pcReg + offsetExt;
            else if (isBeq && flagEReg)      pcNext = pcReg + offsetExt;
            else if (isBgt && flagGtReg)     pcNext = pcReg + offsetExt;
            else                             pcNext = pcReg + PC_W'(1);
`ifdef ILLEGAL_OP_TRAP_EN
            if (trapFire)                    pcNext = TRAP_VEC;
`endif
        end
    end

    // Datapath registers: PC, latched instruction word and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcReg     <= RESET_PC;
            instrReg  <= '0;
            flagEReg  <= 1'b0;
            flagGtReg <= 1'b0;
        end else begin
            pcReg <= pcNext;
            if (stateReg == WAIT && imem.imem_valid) instrReg <= imem.imem_rdata;
            if (execFire && cmp_valid && !trapFire) begin
                flagEReg  <= cmp_eq;
                flagGtReg <= cmp_gt;
            end
        end
    end

    assign imem.imem_addr = pcReg;
    assign instr          = instrReg;
    assign opcode         = instrReg[INSTR_W-1 -: 5];
    assign imm            = instrReg[INSTR_W-6];
    assign link_pc        = pcReg + PC_W'(1);
    assign pc             = pcReg;
    assign flag_e         = flagEReg;
    assign flag_gt        = flagGtReg;
endmodule

// File: tb/tb_fetch_branch_unit.sv
// Self-checking bench for fetch_branch_unit: directed scenarios followed by
// randomized instruction streams, checked against a behavioural PC/flags model.
module tb_fetch_branch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr;
    logic [4:0]  opcode;
    logic        imm, instr_valid;
    logic        exec_done = 0, isBeq = 0, isBgt = 0, isUBranch = 0, isCall = 0, isRet = 0;
    logic        cmp_valid = 0, cmp_eq = 0, cmp_gt = 0;
    logic [15:0] ret_addr = '0;
    logic [15:0] link_pc, pc;
    logic        flag_e, flag_gt, illegal;

    fetch_branch_unit_if #(.PC_W(16), .INSTR_W(32)) imem ();

    fetch_branch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem(imem),
        .instr(instr), .opcode(opcode), .imm(imm), .instr_valid(instr_valid),
        .exec_done(exec_done), .isBeq(isBeq), .isBgt(isBgt), .isUBranch(isUBranch),
        .isCall(isCall), .isRet(isRet), .cmp_valid(cmp_valid), .cmp_eq(cmp_eq),
        .cmp_gt(cmp_gt), .ret_addr(ret_addr), .link_pc(link_pc), .pc(pc),
        .flag_e(flag_e), .flag_gt(flag_gt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int assertCnt = 0;
    int failCnt   = 0;

    // Reference model state.
    int mPc;
    bit mFe, mFg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit isTrapOp(input logic [31:0] w);
`ifdef ILLEGAL_OP_TRAP_EN
        return int'(w[31:27]) >= 21;
`else
        return 1'b0;
`endif
    endfunction

    // Next PC from the architectural rules, using plain integer arithmetic.
    function automatic int modelNext(input int cur, input logic [31:0] w, input bit r,
                                     input bit ub, input bit bq, input bit bg, input int ra);
        int off;
        off = int'(w[26:0]);
        if (w[26]) off = off - 134217728;
        if (isTrapOp(w)) return 4;
        if (r) return ra;
        if (ub || (bq && mFe) || (bg && mFg)) return ((cur + off) % 65536 + 65536) % 65536;
        return (cur + 1) % 65536;
    endfunction

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_req", imem.imem_req, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ivalid", instr_valid, 0);
        chk("rst_flags", {flag_e, flag_gt}, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_instr", instr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mPc = 0; mFe = 0; mFg = 0;
        chk("post_rst_req", imem.imem_req, 0);
    endtask

    // One full instruction: fetch, execute, retire, compare against the model.
    task automatic doTxn(input logic [31:0] w, input int lat, input int hold,
                         input bit r, input bit ub, input bit cl, input bit bq, input bit bg,
                         input bit cv, input bit ce, input bit cg, input logic [15:0] ra);
        int waitCnt, nxt;
        bit trap;
        waitCnt = 0;
        while (!imem.imem_req && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!imem.imem_req) begin
            chk("req_timeout", imem.imem_req, 1);
            return;
        end
        chk("imem_addr", imem.imem_addr, mPc);
        chk("ivalid_fetch", instr_valid, 0);
        for (int k = 0; k < lat; k++) @(negedge clk);
        imem.imem_valid = 1'b1;
        imem.imem_rdata = w;
        @(negedge clk);
        imem.imem_valid = 1'b0;
        imem.imem_rdata = $urandom;
        chk("ivalid_exec", instr_valid, 1);
        chk("req_exec", imem.imem_req, 0);
        chk("instr", instr, w);
        chk("opcode", opcode, w[31:27]);
        chk("imm", imm, w[26]);
        chk("pc_exec", pc, mPc);
        chk("link_pc", link_pc, (mPc + 1) % 65536);
        // Stray fetch-data beats while executing must be ignored.
        for (int k = 0; k < hold; k++) begin
            imem.imem_valid = 1'b1;
            @(negedge clk);
            chk("ivalid_hold", instr_valid, 1);
        end
        imem.imem_valid = 1'b0;
        exec_done = 1; isRet = r; isUBranch = ub; isCall = cl; isBeq = bq; isBgt = bg;
        cmp_valid = cv; cmp_eq = ce; cmp_gt = cg; ret_addr = ra;
        @(negedge clk);
        exec_done = 0; isRet = 0; isUBranch = 0; isCall = 0; isBeq = 0; isBgt = 0;
        cmp_valid = 0; cmp_eq = $urandom; cmp_gt = $urandom; ret_addr = $urandom;
        trap = isTrapOp(w);
        nxt  = modelNext(mPc, w, r, ub || cl, bq, bg, int'(ra));
        if (cv && !trap) begin
            mFe = ce;
            mFg = cg;
        end
        mPc = nxt;
        chk("illegal", illegal, trap);
        chk("flag_e", flag_e, mFe);
        chk("flag_gt", flag_gt, mFg);
        chk("ivalid_done", instr_valid, 0);
        chk("pc_next", pc, mPc);
        $display("txn word=%08h next_pc=%04h flags=%0d%0d", w, mPc, mFe, mFg);
    endtask

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_CMP = 5'b00010;
    localparam logic [4:0] OP_BEQ = 5'b01000;
    localparam logic [4:0] OP_BGT = 5'b01001;
    localparam logic [4:0] OP_B   = 5'b01010;
    localparam logic [4:0] OP_CAL = 5'b01011;
    localparam logic [4:0] OP_RET = 5'b01100;
    localparam logic [4:0] OP_NOP = 5'b01101;

    initial begin
        imem.imem_valid = 1'b0;
        imem.imem_rdata = '0;
        doReset();

        // Sequential fetch 0,1,2,3 with ADDs, flags stay clear.
        for (int i = 0; i < 4; i++)
            doTxn({OP_ADD, 27'(i * 3)}, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        // pc=4,5: ADD then CMP(eq=1); pc=6: BEQ -3 -> 3.
        doTxn({OP_ADD, 27'h0}, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        doTxn({OP_CMP, 27'h0}, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0);
        doTxn({OP_BEQ, 27'h7FFFFFD}, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
        // Repeat with cmp_eq=0: BEQ falls through to 7.
        doTxn({OP_ADD, 27'h0}, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        doTxn({OP_ADD, 27'h0}, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        doTxn({OP_CMP, 27'h0}, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0);
        doTxn({OP_BEQ, 27'h7FFFFFD}, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0);
        // Jump to 10, CALL +20 -> 30, RET to 11.
        doTxn({OP_RET, 27'h0}, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'd10);
        doTxn({OP_CAL, 27'd20}, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 16'h0);
        doTxn({OP_RET, 27'h0}, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'd11);
        // Wrap-around: FFFF + 1 -> 0; then BGT +2 at FFFF with flag_gt=1 -> 1.
        doTxn({OP_RET, 27'h0}, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF);
        doTxn({OP_NOP, 27'h0}, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        doTxn({OP_CMP, 27'h0}, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0);
        doTxn({OP_RET, 27'h0}, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF);
        doTxn({OP_BGT, 27'd2}, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0);
        // Unconditional branch backwards, then illegal opcode at pc=8.
        doTxn({OP_B, 27'h7FFFFFF}, 3, 2, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0);
        doTxn({OP_RET, 27'h0}, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'd8);
        doTxn({5'b11000, 27'h0}, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 16'h0);

        // Reset while a fetch is outstanding; stray imem_valid after release.
        doTxn({OP_RET, 27'h0}, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0123);
        @(negedge clk);
        chk("midfetch_req", imem.imem_req, 1);
        chk("midfetch_addr", imem.imem_addr, 16'h0123);
        #2 rst_n = 1'b0;
        #1;
        chk("midfetch_req_drop", imem.imem_req, 0);
        chk("midfetch_pc", pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mPc = 0; mFe = 0; mFg = 0;
        imem.imem_valid = 1'b1;
        imem.imem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        imem.imem_valid = 1'b0;
        chk("stray_ivalid", instr_valid, 0);
        doTxn({OP_ADD, 27'h5}, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);

        // Randomized instruction stream.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] w;
            bit r, ub, cl, bq, bg;
            w  = $urandom;
            r  = ($urandom_range(0, 7) == 0);
            cl = ($urandom_range(0, 7) == 0);
            ub = cl || ($urandom_range(0, 5) == 0);
            bq = $urandom;
            bg = $urandom;
            doTxn(w, $urandom_range(1, 3), $urandom_range(0, 2), r, ub, cl, bq, bg,
                  1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
